// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: ALU op codes, RISC-V opcode
// values, FSM states and latency classes.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_REM = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SLT = 4'b1010;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;

    typedef enum logic [1:0] {LAT_ONE, LAT_MUL, LAT_DIV} lat_sel_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct3/funct7/imm[11:5] into the ALU op,
// operand-B select, illegal flag and latency class.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [6:0] imm_hi,
    output logic [3:0] op,
    output logic       use_imm,
    output logic       illegal,
    output logic [1:0] lat_sel
);

    always_comb begin
        op      = OP_ADD;
        use_imm = 1'b0;
        illegal = 1'b1;
        lat_sel = LAT_ONE;
        if (opcode == OPC_OP) begin
            case (funct7)
                F7_BASE: begin
                    illegal = 1'b0;
                    case (funct3)
                        3'b000:  op = OP_ADD;
                        3'b001:  op = OP_SLL;
                        3'b010:  op = OP_SLT;
                        3'b100:  op = OP_XOR;
                        3'b101:  op = OP_SRL;
                        3'b110:  op = OP_OR;
                        3'b111:  op = OP_AND;
                        default: illegal = 1'b1;
                    endcase
                end
                F7_ALT: begin
                    if (funct3 == 3'b000) begin
                        op      = OP_SUB;
                        illegal = 1'b0;
                    end
                end
                F7_MULDIV: begin
                    illegal = 1'b0;
                    case (funct3)
                        3'b000: begin op = OP_MUL; lat_sel = LAT_MUL; end
                        3'b100: begin op = OP_DIV; lat_sel = LAT_DIV; end
                        3'b110: begin op = OP_REM; lat_sel = LAT_DIV; end
                        default: illegal = 1'b1;
                    endcase
                end
                default: ;
            endcase
        end else if (opcode == OPC_OPIMM) begin
            use_imm = 1'b1;
            illegal = 1'b0;
            case (funct3)
                3'b000:  op = OP_ADD;
                3'b010:  op = OP_SLT;
                3'b100:  op = OP_XOR;
                3'b110:  op = OP_OR;
                3'b111:  op = OP_AND;
                // srai shares funct3 101 with srli; only zero upper imm bits are legal
                3'b001:  begin op = OP_SLL; illegal = (imm_hi != 7'b0000000); end
                3'b101:  begin op = OP_SRL; illegal = (imm_hi != 7'b0000000); end
                default: illegal = 1'b1;
            endcase
        end
        if (illegal) begin
            op      = OP_ADD;
            lat_sel = LAT_ONE;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/retire controller in front of the combinational ALU: decodes a packet,
// holds ALU operands for the op latency, then presents a registered result.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [31:0] imm,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_sign,
    input  logic        alu_ovf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic        out_sign,
    output logic        out_ovf,
    output logic        out_illegal
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    state_e     state, state_n;
    logic [3:0] cnt;
    logic [3:0] lat_load;
    logic       is_addsub;
    logic       accept;

    logic [3:0] dec_op;
    logic       dec_use_imm;
    logic       dec_ill;
    logic [1:0] dec_lat;

    alu_op_decode u_decode (
        .opcode  (opcode),
        .funct3  (funct3),
        .funct7  (funct7),
        .imm_hi  (imm[11:5]),
        .op      (dec_op),
        .use_imm (dec_use_imm),
        .illegal (dec_ill),
        .lat_sel (dec_lat)
    );

    always_comb begin
        case (dec_lat)
            LAT_MUL: lat_load = MUL_LOAD;
            LAT_DIV: lat_load = DIV_LOAD;
            default: lat_load = '0;
        endcase
    end

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = dec_ill ? HOLD : EXEC;
            EXEC:    if (cnt == 4'd0) state_n = HOLD;
            HOLD:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            is_addsub   <= 1'b0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_sign    <= 1'b0;
            out_ovf     <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                alu_a     <= rs1_val;
                alu_b     <= dec_use_imm ? imm : rs2_val;
                alu_op    <= dec_op;
                cnt       <= lat_load;
                is_addsub <= !dec_ill && (dec_op == OP_ADD || dec_op == OP_SUB);
                // illegal packets skip EXEC, so their result is formed here
                if (dec_ill) begin
                    out_result  <= '0;
                    out_zero    <= 1'b0;
                    out_sign    <= 1'b0;
                    out_ovf     <= 1'b0;
                    out_illegal <= 1'b1;
                end
            end else if (state == EXEC) begin
                if (cnt == 4'd0) begin
                    out_result  <= alu_result;
                    out_zero    <= alu_zero;
                    out_sign    <= alu_sign;
                    out_ovf     <= alu_ovf && is_addsub;
                    out_illegal <= 1'b0;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int unsigned MUL_C = 2;
    localparam int unsigned DIV_C = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_val, rs2_val, imm;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero, alu_sign, alu_ovf;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic        out_zero, out_sign, out_ovf, out_illegal;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_sign(alu_sign), .alu_ovf(alu_ovf),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_sign(out_sign), .out_ovf(out_ovf), .out_illegal(out_illegal)
    );

    function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_MUL:  r = a * b;
            OP_DIV:  r = (b == 0) ? '1 : 32'($signed(a) / $signed(b));
            OP_REM:  r = (b == 0) ? a  : 32'($signed(a) % $signed(b));
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_AND:  r = a & b;
            OP_SLL:  r = a << b[4:0];
            OP_SRL:  r = a >> b[4:0];
            OP_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    // The ALU model raises ovf on every non add/sub op so the controller's masking is visible.
    function automatic logic ref_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = ref_res(op, a, b);
        if (op == OP_ADD) return (a[31] == b[31]) && (r[31] != a[31]);
        if (op == OP_SUB) return (a[31] != b[31]) && (r[31] != a[31]);
        return 1'b1;
    endfunction

    always_comb begin
        alu_result = ref_res(alu_op, alu_a, alu_b);
        alu_zero   = (alu_result == 32'd0);
        alu_sign   = alu_result[31];
        alu_ovf    = ref_ovf(alu_op, alu_a, alu_b);
    end

    typedef struct {
        string       nm;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rs1, rs2, imm;
        logic [3:0]  op;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        z, s, o, ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] im, input logic [3:0] op, input logic ill);
        vec_t v;
        v.nm = nm; v.opc = opc; v.f3 = f3; v.f7 = f7;
        v.rs1 = rs1; v.rs2 = rs2; v.imm = im; v.op = op; v.ill = ill;
        return v;
    endfunction

    function automatic exp_t expect_of(input vec_t v);
        exp_t e;
        logic [31:0] b;
        b = (v.opc == OPC_OPIMM) ? v.imm : v.rs2;
        if (v.ill) begin
            e.res = '0; e.z = 1'b0; e.s = 1'b0; e.o = 1'b0; e.ill = 1'b1;
        end else begin
            e.res = ref_res(v.op, v.rs1, b);
            e.z   = (e.res == 32'd0);
            e.s   = e.res[31];
            e.o   = (v.op == OP_ADD || v.op == OP_SUB) ? ref_ovf(v.op, v.rs1, b) : 1'b0;
            e.ill = 1'b0;
        end
        return e;
    endfunction

    function automatic int lat_of(input vec_t v);
        if (v.ill) return 0;
        if (v.op == OP_MUL) return int'(MUL_C);
        if (v.op == OP_DIV || v.op == OP_REM) return int'(DIV_C);
        return 1;
    endfunction

    task automatic drive(input vec_t v);
        opcode = v.opc; funct3 = v.f3; funct7 = v.f7;
        rs1_val = v.rs1; rs2_val = v.rs2; imm = v.imm;
        in_valid = 1'b1;
        sb.push_back(expect_of(v));
    endtask

    // Waits for out_valid, compares against the scoreboard head, then handshakes.
    task automatic drain(input string nm);
        exp_t e;
        int   n;
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        @(negedge clk);
        check({nm, ".out_valid"}, {31'b0, out_valid}, 32'd1);
        if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s.scoreboard: got empty queue expected an entry", nm);
        end else begin
            e = sb.pop_front();
            check({nm, ".result"},  out_result, e.res);
            check({nm, ".zero"},    {31'b0, out_zero},    {31'b0, e.z});
            check({nm, ".sign"},    {31'b0, out_sign},    {31'b0, e.s});
            check({nm, ".ovf"},     {31'b0, out_ovf},     {31'b0, e.o});
            check({nm, ".illegal"}, {31'b0, out_illegal}, {31'b0, e.ill});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, ".valid_drop"}, {31'b0, out_valid}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        @(negedge clk);
        check({v.nm, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        drive(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!v.ill) begin
            check({v.nm, ".alu_op"}, {28'b0, alu_op}, {28'b0, v.op});
            check({v.nm, ".alu_a"},  alu_a, v.rs1);
            check({v.nm, ".alu_b"},  alu_b, (v.opc == OPC_OPIMM) ? v.imm : v.rs2);
        end
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        check({v.nm, ".latency"}, 32'(n), 32'(lat_of(v)));
        drain(v.nm);
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = mk("addi",     OPC_OPIMM, 3'b000, 7'h00, 32'd5,        32'hDEADBEEF, 32'hFFFFFFF9, OP_ADD, 1'b0);
        vecs[1]  = mk("mul",      OPC_OP,    3'b000, 7'h01, 32'd7,        32'd6,        32'hDEADBEEF, OP_MUL, 1'b0);
        vecs[2]  = mk("sub_ovf",  OPC_OP,    3'b000, 7'h20, 32'h80000000, 32'd1,        32'hDEADBEEF, OP_SUB, 1'b0);
        vecs[3]  = mk("add_ovf",  OPC_OP,    3'b000, 7'h00, 32'h7FFFFFFF, 32'd1,        32'hDEADBEEF, OP_ADD, 1'b0);
        vecs[4]  = mk("srai_ill", OPC_OPIMM, 3'b101, 7'h00, 32'hFFFF0000, 32'd0,        32'h00000403, OP_ADD, 1'b1);
        vecs[5]  = mk("slli",     OPC_OPIMM, 3'b001, 7'h00, 32'd1,        32'hDEADBEEF, 32'd3,        OP_SLL, 1'b0);
        vecs[6]  = mk("div",      OPC_OP,    3'b100, 7'h01, 32'd100,      32'd7,        32'hDEADBEEF, OP_DIV, 1'b0);
        vecs[7]  = mk("rem",      OPC_OP,    3'b110, 7'h01, 32'd100,      32'd7,        32'hDEADBEEF, OP_REM, 1'b0);
        vecs[8]  = mk("sltu_ill", OPC_OP,    3'b011, 7'h00, 32'd1,        32'd2,        32'hDEADBEEF, OP_ADD, 1'b1);
        vecs[9]  = mk("xor_zero", OPC_OP,    3'b100, 7'h00, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hDEADBEEF, OP_XOR, 1'b0);
        vecs[10] = mk("slt",      OPC_OP,    3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,        32'hDEADBEEF, OP_SLT, 1'b0);
        vecs[11] = mk("andi",     OPC_OPIMM, 3'b111, 7'h00, 32'hF0F0F0F0, 32'hDEADBEEF, 32'h0000FFFF, OP_AND, 1'b0);
        vecs[12] = mk("srl",      OPC_OP,    3'b101, 7'h00, 32'h80000000, 32'd4,        32'hDEADBEEF, OP_SRL, 1'b0);
        vecs[13] = mk("mulh_ill", OPC_OP,    3'b001, 7'h01, 32'd3,        32'd4,        32'hDEADBEEF, OP_ADD, 1'b1);
        vecs[14] = mk("lui_ill",  7'b0110111, 3'b000, 7'h00, 32'd3,       32'd4,        32'hDEADBEEF, OP_ADD, 1'b1);
        vecs[15] = mk("or",       OPC_OP,    3'b110, 7'h00, 32'h00000F00, 32'h000000F0, 32'hDEADBEEF, OP_OR,  1'b0);

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; funct3 = '0; funct7 = '0; rs1_val = '0; rs2_val = '0; imm = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid",   {31'b0, out_valid},   32'd0);
        check("rst.in_ready",    {31'b0, in_ready},    32'd0);
        check("rst.alu_op",      {28'b0, alu_op},      32'd0);
        check("rst.alu_a",       alu_a,                32'd0);
        check("rst.out_illegal", {31'b0, out_illegal}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst.in_ready_rel", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // Backpressure: a second packet waits while the first result is stalled.
        begin
            vec_t p1, p2;
            p1 = mk("bp_add", OPC_OP,    3'b000, 7'h00, 32'd10,       32'd20,       32'hDEADBEEF, OP_ADD, 1'b0);
            p2 = mk("bp_ori", OPC_OPIMM, 3'b110, 7'h00, 32'h000000F0, 32'hDEADBEEF, 32'h0000000F, OP_OR,  1'b0);
            @(negedge clk);
            drive(p1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int n = 0; n < 40 && !out_valid; n++) begin @(posedge clk); #1; end
            @(negedge clk);
            drive(p2);
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                check("bp.out_valid",  {31'b0, out_valid}, 32'd1);
                check("bp.in_ready",   {31'b0, in_ready},  32'd0);
                check("bp.out_result", out_result,         32'd30);
                check("bp.alu_op",     {28'b0, alu_op},    {28'b0, OP_ADD});
            end
            drain("bp_add");
            check("bp.in_ready_after", {31'b0, in_ready}, 32'd1);
            check("bp.not_yet",        {28'b0, alu_op},   {28'b0, OP_ADD});
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("bp.accepted_op", {28'b0, alu_op}, {28'b0, OP_OR});
            check("bp.accepted_b",  alu_b,           32'h0000000F);
            drain("bp_ori");
        end

        // Reset two cycles into a div aborts it.
        begin
            vec_t d;
            d = mk("rst_div", OPC_OP, 3'b100, 7'h01, 32'd50, 32'd5, 32'hDEADBEEF, OP_DIV, 1'b0);
            @(negedge clk);
            opcode = d.opc; funct3 = d.f3; funct7 = d.f7;
            rs1_val = d.rs1; rs2_val = d.rs2; imm = d.imm;
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("rd.alu_op_div", {28'b0, alu_op}, {28'b0, OP_DIV});
            @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            #1;
            check("rd.in_ready_gated", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
            check("rd.out_valid", {31'b0, out_valid}, 32'd0);
            check("rd.alu_op",    {28'b0, alu_op},    32'd0);
            check("rd.in_ready",  {31'b0, in_ready},  32'd0);
            @(negedge clk);
            reset = 1'b0;
            #1;
            check("rd.in_ready_rel", {31'b0, in_ready}, 32'd1);
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                check("rd.no_stale", {31'b0, out_valid}, 32'd0);
            end
        end

        if (sb.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard.leftover: got %0d entries expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue/retire controller that sits in front of the combinational ALU. It accepts a decoded-field instruction packet over a valid/ready handshake and translates RISC-V opcode/funct3/funct7 into the ALU's 4-bit OP encoding. It holds operands stable for the per-op latency (multi-cycle path for mul/div), then registers the ALU result and flags into an output valid/ready stage.

## Interface
- MUL_CYCLES, 2, cycles operands are held before the mul result is sampled; legal range 1..15.
- DIV_CYCLES, 4, cycles held for div/rem; legal range 1..15.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request packet valid.
- in_ready  out  1  controller can accept a packet.
- opcode  in  7  instruction opcode field.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field.
- rs1_val  in  32  source operand 1.
- rs2_val  in  32  source operand 2 (R-type).
- imm  in  32  sign-extended immediate (I-type).
- alu_a, alu_b  out  32  operands to the ALU A_/B_ inputs.
- alu_op  out  4  OP to the ALU.
- alu_result  in  32  ALU result.
- alu_zero, alu_sign, alu_ovf  in  1  ALU flags.
- out_valid  out  1  result packet valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  32  registered result.
- out_zero, out_sign, out_ovf  out  1  registered flags.
- out_illegal  out  1  packet was not a supported encoding.

## Operation
- Decode, R-type (opcode 0110011): funct7 0000000 with funct3 000/001/010/100/101/110/111 gives add 0000, sll 1000, slt 1010, xor 0110, srl 1001, or 0101, and 0111. funct7 0100000 with funct3 000 gives sub 0001. funct7 0000001 with funct3 000/100/110 gives mul 0010, div 0011, rem 0100. B = rs2_val.
- Decode, I-type (opcode 0010011): funct3 000/010/100/110/111 gives add/slt/xor/or/and. funct3 001 and 101 give sll/srl, and only when imm[11:5]=0000000. B = imm.
- Every other encoding is illegal, including sltu, sra/srai, mulh*, divu, remu and other opcodes.
- A = rs1_val for all legal ops.
- Latency L: 1 for single-cycle ops, MUL_CYCLES for mul, DIV_CYCLES for div/rem.
- FSM IDLE: in_ready=1. On in_valid&&in_ready, alu_a/alu_b/alu_op are registered and a 4-bit counter is loaded with L-1. The next state is EXEC, or HOLD directly if illegal.
- FSM EXEC: the counter decrements each cycle. When it reaches 0, alu_result and the flags are captured into out_*, and the next state is HOLD.
- FSM HOLD: out_valid=1. When out_ready=1 the next state is IDLE.
- out_ovf equals alu_ovf only for add/sub and is forced to 0 for all other ops.
- out_zero and out_sign are passed through from the ALU.
- Illegal packet: out_result=0, out_zero=0, out_sign=0, out_ovf=0, out_illegal=1. The ALU is not waited on.
- alu_a, alu_b and alu_op stay constant from accept until the next accept.
- in_ready=0 in EXEC and HOLD. in_valid is ignored there and the packet is not consumed.

## Timing
- Accept at edge k. The ALU inputs are valid after k. Results are sampled at edge k+L, and out_valid is high from k+L until the out_ready edge.
- The earliest next accept is the edge after the out_valid&&out_ready edge. This gives a throughput of 1 op per L+2 cycles.
- While out_valid=1 and out_ready=0, all out_* hold stable.
- in_ready is a pure function of state and is gated low while reset=1.
- Reset value of every registered output is 0, including out_valid, out_illegal, alu_a, alu_b and alu_op (0000). The state resets to IDLE and the counter to 0.
- Reset asserted in EXEC or HOLD aborts the op. The next cycle shows out_valid=0, and no stale result is ever presented.

## Structure
- Shared package alu_pkg holds:
  - OP constants (OP_ADD..OP_SLT, 4'b0000..4'b1010);
  - opcode constants OPC_OP=7'b0110011 and OPC_OPIMM=7'b0010011;
  - the FSM state enum (IDLE, EXEC, HOLD).
- Sub-module alu_op_decode is combinational. It maps opcode/funct3/funct7/imm[11:5] to {op, use_imm, illegal, lat_sel}.
- The ALU itself stays outside this block and is connected port-to-port.

## Test plan
- addi: opcode 0010011, funct3 000, rs1_val=5, imm=0xFFFFFFF9. Expect alu_op=0000, alu_b=0xFFFFFFF9, out_result=0xFFFFFFFE, out_sign=1, and out_valid one cycle after accept.
- mul with MUL_CYCLES=2: R-type funct7 0000001, funct3 000, 7×6. Expect out_valid exactly 2 edges after accept, with out_result=42 and out_ovf=0.
- sub overflow: 0x80000000 − 1. Expect out_result=0x7FFFFFFF, out_ovf=1, out_zero=0.
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1 is applied. Expect out_* stable, in_ready=0, and the pending packet accepted only on the edge after the result handshake.
- Illegal: srai encoding (funct3 101, imm[11:5]=0100000). Expect out_valid on the edge after accept, with out_illegal=1 and out_result=0.
- Reset mid-div with DIV_CYCLES=4: assert reset 2 cycles after accept. Expect out_valid=0 and alu_op=0000 on the following cycle, and in_ready=1 only after reset deasserts.
